// File: rtl/ram_arbiter.sv
// Shares the single external RAM port between instruction fetch and the data cache.
// Define ARB_RR_EN for round-robin tie-break; otherwise the cache always wins ties.
module ram_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   output logic        if_done_o,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        mem_done_o,
   output logic        err_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_data_o,
   output logic        ram_we_o,
   output logic [3:0]  ram_sel_o,
   output logic        ram_ce_o,
   input  logic [31:0] ram_data_i,
   input  logic        ram_data_ready,
   output logic        stallreq_if_o,
   output logic        stallreq_mem_o
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_MEM,
      RESP
   } state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t      r_state;
   state_t      w_state_n;
   logic [31:0] r_addr;
   logic [31:0] w_addr_n;
   logic [31:0] r_wdata;
   logic [31:0] w_wdata_n;
   logic [31:0] r_rdata;
   logic [31:0] w_rdata_n;
   logic        r_we;
   logic        w_we_n;
   logic [3:0]  r_sel;
   logic [3:0]  w_sel_n;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_n;
   logic        r_err;
   logic        w_err_n;
   logic        r_gnt_mem;
   logic        w_gnt_mem_n;

   logic        w_grant;
   logic        w_pick_mem;
   logic        w_busy;
   logic        w_resp;

   assign w_grant = (r_state == IDLE) & (if_req_i | mem_req_i);

`ifdef ARB_RR_EN
   // Remembers who won the previous grant; reset to fetch so the first tie goes to the cache.
   logic r_last_mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_mem <= 1'b0;
      end else if (w_grant) begin
         r_last_mem <= w_pick_mem;
      end
   end

   assign w_pick_mem = mem_req_i & (~if_req_i | ~r_last_mem);
`else
   assign w_pick_mem = mem_req_i;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_addr_n    = r_addr;
      w_wdata_n   = r_wdata;
      w_rdata_n   = r_rdata;
      w_we_n      = r_we;
      w_sel_n     = r_sel;
      w_cnt_n     = r_cnt;
      w_err_n     = r_err;
      w_gnt_mem_n = r_gnt_mem;
      unique case (r_state)
         IDLE: begin
            if (w_grant) begin
               w_cnt_n     = '0;
               w_err_n     = 1'b0;
               w_gnt_mem_n = w_pick_mem;
               if (w_pick_mem) begin
                  w_state_n = BUSY_MEM;
                  w_addr_n  = mem_addr_i;
                  w_we_n    = mem_we_i;
                  w_sel_n   = mem_sel_i;
                  w_wdata_n = mem_data_i;
               end else begin
                  w_state_n = BUSY_IF;
                  w_addr_n  = if_addr_i;
                  w_we_n    = 1'b0;
                  w_sel_n   = 4'b1111;
                  w_wdata_n = '0;
               end
            end
         end
         BUSY_IF, BUSY_MEM: begin
            // Completion is checked before the watchdog so a late ack still wins.
            if (ram_data_ready) begin
               w_rdata_n = r_we ? 32'd0 : ram_data_i;
               w_state_n = RESP;
            end else if (r_cnt == TMO) begin
               w_rdata_n = '0;
               w_err_n   = 1'b1;
               w_state_n = RESP;
            end else begin
               w_cnt_n = r_cnt + 8'd1;
            end
         end
         RESP: begin
            w_state_n = IDLE;
         end
         default: begin
            w_state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_we      <= 1'b0;
         r_sel     <= '0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
         r_gnt_mem <= 1'b0;
      end else begin
         r_addr    <= w_addr_n;
         r_wdata   <= w_wdata_n;
         r_rdata   <= w_rdata_n;
         r_we      <= w_we_n;
         r_sel     <= w_sel_n;
         r_cnt     <= w_cnt_n;
         r_err     <= w_err_n;
         r_gnt_mem <= w_gnt_mem_n;
      end
   end

   assign w_busy = (r_state == BUSY_IF) | (r_state == BUSY_MEM);
   assign w_resp = (r_state == RESP);

   assign ram_ce_o   = w_busy;
   assign ram_addr_o = w_busy ? r_addr : 32'd0;
   assign ram_data_o = w_busy ? r_wdata : 32'd0;
   assign ram_we_o   = w_busy & r_we;
   assign ram_sel_o  = w_busy ? r_sel : 4'd0;

   assign if_done_o  = w_resp & ~r_gnt_mem;
   assign mem_done_o = w_resp & r_gnt_mem;
   assign err_o      = w_resp & r_err;
   assign if_data_o  = if_done_o ? r_rdata : 32'd0;
   assign mem_data_o = mem_done_o ? r_rdata : 32'd0;

   assign stallreq_if_o  = if_req_i & ~if_done_o;
   assign stallreq_mem_o = mem_req_i & ~mem_done_o;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: planned grant order, RAM responder, done monitor.
// Build with +define+ARB_RR_EN to exercise round-robin tie-breaks.
module tb_ram_arbiter;

   localparam int TMO = 4;

   typedef struct {
      bit          is_mem;
      logic [31:0] addr;
      bit          we;
      logic [3:0]  sel;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rdata;
      bit          err;
      int          lat;
   } tx_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_done_o;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        mem_done_o;
   logic        err_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_data_o;
   logic        ram_we_o;
   logic [3:0]  ram_sel_o;
   logic        ram_ce_o;
   logic [31:0] ram_data_i;
   logic        ram_data_ready;
   logic        stallreq_if_o;
   logic        stallreq_mem_o;

   ram_arbiter #(.TIMEOUT(TMO)) dut (
      .clk            (clk),
      .rst            (rst),
      .if_req_i       (if_req_i),
      .if_addr_i      (if_addr_i),
      .if_data_o      (if_data_o),
      .if_done_o      (if_done_o),
      .mem_req_i      (mem_req_i),
      .mem_we_i       (mem_we_i),
      .mem_sel_i      (mem_sel_i),
      .mem_addr_i     (mem_addr_i),
      .mem_data_i     (mem_data_i),
      .mem_data_o     (mem_data_o),
      .mem_done_o     (mem_done_o),
      .err_o          (err_o),
      .ram_addr_o     (ram_addr_o),
      .ram_data_o     (ram_data_o),
      .ram_we_o       (ram_we_o),
      .ram_sel_o      (ram_sel_o),
      .ram_ce_o       (ram_ce_o),
      .ram_data_i     (ram_data_i),
      .ram_data_ready (ram_data_ready),
      .stallreq_if_o  (stallreq_if_o),
      .stallreq_mem_o (stallreq_mem_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_tests = 0;
   int          n_fail = 0;
   tx_t         exp_q[$];
   tx_t         req_q[$];
   tx_t         mem_tx[$];
   tx_t         if_tx[$];
   logic [31:0] ref_mem[16];
   logic [31:0] ram_mem[16];
   bit          last_mem = 1'b0;
   int          last_rise = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic tx_t new_if(input logic [31:0] a, input int d);
      tx_t t;
      t.is_mem = 1'b0; t.addr = a; t.we = 1'b0; t.sel = 4'hf;
      t.wdata = '0; t.delay = d; t.rdata = '0; t.err = 1'b0; t.lat = 0;
      return t;
   endfunction

   function automatic tx_t new_mem(input logic [31:0] a, input bit we, input logic [3:0] s,
                                   input logic [31:0] wd, input int d);
      tx_t t;
      t.is_mem = 1'b1; t.addr = a; t.we = we; t.sel = s;
      t.wdata = wd; t.delay = d; t.rdata = '0; t.err = 1'b0; t.lat = 0;
      return t;
   endfunction

   function automatic int rand_delay();
      int r;
      r = $urandom_range(0, 9);
      if (r <= TMO) return r;
      if (r <= 6) return TMO;
      if (r == 7) return TMO + 1;
      return 1;
   endfunction

   // Reference: with both requesters holding from the same cycle, fixed priority
   // drains the cache first; round-robin alternates starting from the non-last winner.
   task automatic plan();
      int  im = 0;
      int  ii = 0;
      bit  pick;
      tx_t t;
      while (im < mem_tx.size() || ii < if_tx.size()) begin
         if (ii == if_tx.size()) pick = 1'b1;
         else if (im == mem_tx.size()) pick = 1'b0;
         else begin
`ifdef ARB_RR_EN
            pick = !last_mem;
`else
            pick = 1'b1;
`endif
         end
         last_mem = pick;
         if (pick) begin
            t = mem_tx[im];
            im++;
         end else begin
            t = if_tx[ii];
            ii++;
         end
         if (t.delay > TMO) begin
            t.err = 1'b1; t.rdata = '0; t.lat = TMO + 1;
         end else begin
            t.err = 1'b0; t.lat = t.delay + 1;
            if (t.we) begin
               t.rdata = '0;
               ref_mem[t.addr[3:0]] = merge(ref_mem[t.addr[3:0]], t.wdata, t.sel);
            end else begin
               t.rdata = ref_mem[t.addr[3:0]];
            end
         end
         exp_q.push_back(t);
         req_q.push_back(t);
      end
   endtask

   task automatic drive_mem(input tx_t t);
      mem_req_i  = 1'b1;
      mem_addr_i = t.addr;
      mem_we_i   = t.we;
      mem_sel_i  = t.sel;
      mem_data_i = t.wdata;
   endtask

   task automatic run_round();
      int nm = mem_tx.size();
      int ni = if_tx.size();
      int mi = 0;
      int ii = 0;
      int g = 0;
      bit md;
      bit id;
      plan();
      @(negedge clk);
      #1;
      if (nm > 0) drive_mem(mem_tx[0]);
      if (ni > 0) begin
         if_req_i  = 1'b1;
         if_addr_i = if_tx[0].addr;
      end
      while ((mi < nm || ii < ni) && g < 500) begin
         @(negedge clk);
         g++;
         md = mem_done_o;
         id = if_done_o;
         #1;
         if (md) begin
            mi++;
            if (mi < nm) drive_mem(mem_tx[mi]);
            else mem_req_i = 1'b0;
         end
         if (id) begin
            ii++;
            if (ii < ni) if_addr_i = if_tx[ii].addr;
            else if_req_i = 1'b0;
         end
      end
      n_tests++;
      if (g >= 500) begin
         n_fail++;
         $display("FAIL round_budget: %0d cycles without all dones, need < 500", g);
         mem_req_i = 1'b0;
         if_req_i  = 1'b0;
      end
      mem_tx.delete();
      if_tx.delete();
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic reset_abort();
      req_q.push_back(new_mem(32'h44, 1'b0, 4'hf, 32'h0, 99));
      @(negedge clk);
      #1;
      drive_mem(new_mem(32'h44, 1'b0, 4'hf, 32'h0, 99));
      @(negedge clk);
      chk("rst_ce_before", ram_ce_o, 1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      mem_req_i = 1'b0;
      @(negedge clk);
      chk("rst_ce", ram_ce_o, 0);
      chk("rst_addr", ram_addr_o, 0);
      chk("rst_we", ram_we_o, 0);
      chk("rst_sel", ram_sel_o, 0);
      chk("rst_data", ram_data_o, 0);
      chk("rst_mem_done", mem_done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_stall_mem", stallreq_mem_o, 0);
      #1;
      rst = 1'b0;
      last_mem = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // RAM model: answers each request after its planned delay, noise on ready while idle.
   initial begin
      tx_t r;
      int  n;
      ram_data_ready = 1'b0;
      ram_data_i = '0;
      forever begin
         @(negedge clk);
         ram_data_ready = 1'b0;
         if (ram_ce_o) begin
            if (req_q.size() == 0) begin
               chk("ram_unexpected_ce", ram_ce_o, 0);
            end else begin
               r = req_q.pop_front();
               last_rise = cyc;
               n = 0;
               while (ram_ce_o && n < 300) begin
                  chk("ram_addr", ram_addr_o, r.addr);
                  chk("ram_we", ram_we_o, r.we);
                  chk("ram_sel", ram_sel_o, r.sel);
                  if (r.we) chk("ram_wdata", ram_data_o, r.wdata);
                  if (n == r.delay) begin
                     ram_data_ready = 1'b1;
                     if (r.we) begin
                        ram_data_i = $urandom;
                        ram_mem[r.addr[3:0]] = merge(ram_mem[r.addr[3:0]], r.wdata, r.sel);
                     end else begin
                        ram_data_i = ram_mem[r.addr[3:0]];
                     end
                  end
                  @(negedge clk);
                  ram_data_ready = 1'b0;
                  ram_data_i = $urandom;
                  n++;
               end
               chk("ram_ce_bounded", n < 300, 1);
            end
         end else begin
            ram_data_ready = ($urandom_range(0, 3) == 0);
            ram_data_i = $urandom;
         end
      end
   end

   always @(negedge clk) begin
      tx_t e;
      chk("stall_if", stallreq_if_o, if_done_o ? 1'b0 : if_req_i);
      chk("stall_mem", stallreq_mem_o, mem_done_o ? 1'b0 : mem_req_i);
      chk("dual_done", mem_done_o & if_done_o, 0);
      if (mem_done_o || if_done_o) begin
         if (exp_q.size() == 0) begin
            chk("done_unexpected", {mem_done_o, if_done_o}, 0);
         end else begin
            e = exp_q.pop_front();
            chk("done_who", mem_done_o, e.is_mem);
            chk("done_data", e.is_mem ? mem_data_o : if_data_o, e.rdata);
            chk("done_err", err_o, e.err);
            chk("done_latency", cyc - last_rise, e.lat);
         end
      end else begin
         chk("err_without_done", err_o, 0);
      end
   end

   initial begin
      int nm;
      int ni;
      rst = 1'b1;
      if_req_i = 1'b0;
      if_addr_i = '0;
      mem_req_i = 1'b0;
      mem_we_i = 1'b0;
      mem_sel_i = '0;
      mem_addr_i = '0;
      mem_data_i = '0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         ram_mem[i] = ref_mem[i];
      end
      ref_mem[0] = 32'hDEAD_BEEF;
      ram_mem[0] = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      chk("reset_ce", ram_ce_o, 0);
      chk("reset_addr", ram_addr_o, 0);
      chk("reset_wdata", ram_data_o, 0);
      chk("reset_we", ram_we_o, 0);
      chk("reset_sel", ram_sel_o, 0);
      chk("reset_if_done", if_done_o, 0);
      chk("reset_mem_done", mem_done_o, 0);
      chk("reset_err", err_o, 0);
      chk("reset_if_data", if_data_o, 0);
      chk("reset_mem_data", mem_data_o, 0);
      #1;
      rst = 1'b0;

      if_tx.push_back(new_if(32'h0000_0100, 1));
      run_round();
      mem_tx.push_back(new_mem(32'h20, 1'b1, 4'b0011, 32'h1234_5678, 3));
      run_round();
      for (int i = 0; i < 3; i++)
         mem_tx.push_back(new_mem(32'h30 + i, 1'b0, 4'hf, 32'h0, 0));
      if_tx.push_back(new_if(32'h108, 0));
      run_round();
      mem_tx.push_back(new_mem(32'h24, 1'b0, 4'hf, 32'h0, 50));
      run_round();
      if_tx.push_back(new_if(32'h10c, TMO));
      run_round();
      reset_abort();
      if_tx.push_back(new_if(32'h200, 0));
      run_round();

      for (int r = 0; r < 60; r++) begin
         nm = $urandom_range(0, 3);
         ni = $urandom_range(0, 2);
         if (nm == 0 && ni == 0) ni = 1;
         for (int k = 0; k < nm; k++)
            mem_tx.push_back(new_mem($urandom, 1'($urandom_range(0, 1)),
                                     4'($urandom), $urandom, rand_delay()));
         for (int k = 0; k < ni; k++)
            if_tx.push_back(new_if($urandom, rand_delay()));
         run_round();
      end

      repeat (3) @(negedge clk);
      chk("pending_dones", exp_q.size(), 0);
      chk("pending_ram_reqs", req_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter sharing the single external RAM port between instruction fetch (pc_reg/if_id side) and the data cache's refill/write-through path. Accepts one word transaction at a time, drives the `ram_*` handshake with `ram_data_ready` completion, returns data with a registered done pulse, and raises per-requester stall requests into ctrl while a request is outstanding. A watchdog counter aborts transactions the RAM never acknowledges.

## Interface
- `TIMEOUT`, 255: cycles in a busy state without `ram_data_ready` before abort; range 1..255, 8-bit counter.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req_i` in 1: fetch request; held until `if_done_o`.
- `if_addr_i` in 32: fetch word address.
- `if_data_o` out 32: fetched word, valid while `if_done_o`=1.
- `if_done_o` out 1: one-cycle completion pulse for fetch.
- `mem_req_i` in 1: cache request; held until `mem_done_o`.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_sel_i` in 4: byte enables.
- `mem_addr_i` in 32: cache word address.
- `mem_data_i` in 32: write data.
- `mem_data_o` out 32: read word, valid while `mem_done_o`=1.
- `mem_done_o` out 1: one-cycle completion pulse for cache.
- `err_o` out 1: one-cycle pulse coincident with a done pulse when the transaction timed out.
- `ram_addr_o` out 32, `ram_data_o` out 32, `ram_we_o` out 1, `ram_sel_o` out 4, `ram_ce_o` out 1: external RAM request.
- `ram_data_i` in 32: RAM read data, valid when `ram_data_ready`=1.
- `ram_data_ready` in 1: RAM completion, one-cycle pulse.
- `stallreq_if_o` out 1, `stallreq_mem_o` out 1: to ctrl.

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE: sample requests. `mem_req_i` alone → BUSY_MEM; `if_req_i` alone → BUSY_IF; both → per priority rule (see Configuration). On grant, latch address, we, sel, write data into registers; clear watchdog counter.
- BUSY_x: `ram_ce_o`=1 and `ram_*` driven from latched registers (stable whole transaction). Fetch grants drive `ram_we_o`=0, `ram_sel_o`=4'b1111. On `ram_data_ready`=1: capture `ram_data_i` (reads) or 0 (writes), → RESP. Else counter increments; at count == `TIMEOUT` → RESP with captured data 0 and timeout flag set.
- RESP: `ram_ce_o`=0; assert done of the granted requester (plus `err_o` if timed out) for exactly one cycle; requests ignored; → IDLE.
- Request inputs changing while granted are ignored (latched copy used).
- `stallreq_x_o` = `x_req_i` & ~`x_done_o` (combinational), so the pipeline is released in the done cycle.
- `ram_data_ready` outside BUSY states is ignored.

## Timing
- Reset: state IDLE, all outputs 0, data registers 0, counter 0, last-grant register = IF.
- Request seen at edge t → `ram_ce_o` high from t+1; ready at cycle k (≥ t+1) → done high in cycle k+1 → IDLE at k+2; new grant earliest edge k+2.
- Minimum transaction: 3 cycles req-to-IDLE-return; zero-wait RAM gives done 2 cycles after request edge.
- Timeout: with no ready, done+`err_o` asserted `TIMEOUT`+1 cycles after `ram_ce_o` rises.
- Ready in the same cycle the counter reaches `TIMEOUT`: ready wins, no error.
- Reset mid-transaction: abort immediately, `ram_ce_o` low next cycle, no done pulse.
- Requester must deassert req in its done cycle or it is re-granted as a new transaction.

## Configuration
- `ARB_RR_EN` undefined: fixed priority, cache always beats fetch on simultaneous requests (older instruction first).
- `ARB_RR_EN` defined: round-robin; on simultaneous requests grant the requester not granted last; last-grant register updated on each grant, reset to IF (first tie goes to cache). Single requests granted identically in both modes.

## Test plan
- Fetch only, addr 0x0000_0100, RAM ready 1 cycle after ce with 0xDEADBEEF → `if_data_o`=0xDEADBEEF, `if_done_o` one cycle, `ram_we_o`=0, `ram_sel_o`=4'b1111.
- Cache write addr 0x20, data 0x1234_5678, sel 4'b0011, 3-cycle RAM wait → ram outputs stable 4 cycles, `mem_done_o` pulse, `mem_data_o`=0.
- Both requests together, three back-to-back rounds → fixed: MEM,MEM,MEM then IF; with `ARB_RR_EN`: MEM,IF,MEM.
- `TIMEOUT`=4, no ready → done+`err_o` 5 cycles after ce rise, data 0; ready in the timeout cycle → no `err_o`.
- `rst` asserted 2 cycles into a BUSY_MEM → all outputs 0 next cycle, no done; fresh fetch then completes normally.
- `stallreq_if_o` high from request cycle through cycle before `if_done_o`, low in done cycle.
